// File: rtl/mc_main_ctrl_pkg.sv
// rtl/mc_main_ctrl_pkg.sv - shared opcode, state and select encodings for the main control FSM
package mc_main_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_MADR = 4'd2,
    S_MRD  = 4'd3,
    S_MWB  = 4'd4,
    S_MWR  = 4'd5,
    S_REXE = 4'd6,
    S_RWB  = 4'd7,
    S_BEQ  = 4'd8,
    S_JMP  = 4'd9,
    S_IEXE = 4'd10,
    S_IWB  = 4'd11,
    S_ILL  = 4'd15
  } state_t;

  // ALUOp codes are shared with the downstream ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] ALUSRCB_B       = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_main_ctrl.sv
// rtl/mc_main_ctrl.sv - multi-cycle MIPS main control FSM with retired-instruction counter
module mc_main_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Op,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             IllegalOp,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCnt
);
  import mc_main_ctrl_pkg::*;

  state_t state_q, state_d;
  ctrl_t  ctrl_raw, ctrl;
  logic   retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IF;
      InstrCnt <= '0;
    end else begin
      state_q <= state_d;
      if (retire) InstrCnt <= InstrCnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    ctrl_raw = '0;
    retire   = 1'b0;
    case (state_q)
      S_IF: begin
        ctrl_raw.mem_read  = 1'b1;
        ctrl_raw.alu_src_b = ALUSRCB_FOUR;
        ctrl_raw.alu_op    = ALUOP_ADD;
        ctrl_raw.pc_source = PCSRC_ALU;
        // Latch IR and advance PC only on the cycle the fetch actually completes
        ctrl_raw.ir_write  = MemReady;
        ctrl_raw.pc_write  = MemReady;
        if (MemReady) state_d = S_ID;
      end
      S_ID: begin
        ctrl_raw.alu_src_b = ALUSRCB_IMM_SH2;
        ctrl_raw.alu_op    = ALUOP_ADD;
        case (Op)
          OP_LW, OP_SW: state_d = S_MADR;
          OP_RTYPE:     state_d = S_REXE;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JMP;
          OP_ADDI:      state_d = S_IEXE;
          default:      state_d = S_ILL;
        endcase
      end
      S_MADR: begin
        ctrl_raw.alu_src_a = 1'b1;
        ctrl_raw.alu_src_b = ALUSRCB_IMM;
        ctrl_raw.alu_op    = ALUOP_ADD;
        state_d = (Op == OP_LW) ? S_MRD : S_MWR;
      end
      S_MRD: begin
        ctrl_raw.mem_read = 1'b1;
        ctrl_raw.iord     = 1'b1;
        if (MemReady) state_d = S_MWB;
      end
      S_MWB: begin
        ctrl_raw.reg_write  = 1'b1;
        ctrl_raw.mem_to_reg = 1'b1;
        state_d = S_IF;
        retire  = 1'b1;
      end
      S_MWR: begin
        ctrl_raw.mem_write = 1'b1;
        ctrl_raw.iord      = 1'b1;
        if (MemReady) begin
          state_d = S_IF;
          retire  = 1'b1;
        end
      end
      S_REXE: begin
        ctrl_raw.alu_src_a = 1'b1;
        ctrl_raw.alu_src_b = ALUSRCB_B;
        ctrl_raw.alu_op    = ALUOP_RTYPE;
        state_d = S_RWB;
      end
      S_RWB: begin
        ctrl_raw.reg_write = 1'b1;
        ctrl_raw.reg_dst   = 1'b1;
        state_d = S_IF;
        retire  = 1'b1;
      end
      S_BEQ: begin
        ctrl_raw.alu_src_a     = 1'b1;
        ctrl_raw.alu_src_b     = ALUSRCB_B;
        ctrl_raw.alu_op        = ALUOP_SUB;
        ctrl_raw.pc_write_cond = 1'b1;
        ctrl_raw.pc_source     = PCSRC_ALUOUT;
        state_d = S_IF;
        retire  = 1'b1;
      end
      S_JMP: begin
        ctrl_raw.pc_write  = 1'b1;
        ctrl_raw.pc_source = PCSRC_JUMP;
        state_d = S_IF;
        retire  = 1'b1;
      end
      S_IEXE: begin
        ctrl_raw.alu_src_a = 1'b1;
        ctrl_raw.alu_src_b = ALUSRCB_IMM;
        ctrl_raw.alu_op    = ALUOP_ADD;
        state_d = S_IWB;
      end
      S_IWB: begin
        ctrl_raw.reg_write = 1'b1;
        state_d = S_IF;
        retire  = 1'b1;
      end
      S_ILL: begin
        ctrl_raw.illegal_op = 1'b1;
        state_d = S_ILL;
      end
      default: state_d = S_IF;
    endcase
  end

  // Hold every control line low while in reset so nothing fires before the first fetch
  assign ctrl = rst_n ? ctrl_raw : '0;

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign IllegalOp   = ctrl.illegal_op;
  assign State       = state_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb/tb_mc_main_ctrl.sv - directed self-checking bench for mc_main_ctrl (4-bit counter build)
module tb_mc_main_ctrl;

  localparam int CNT_W = 4;

  // Output vector order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSource IllegalOp
  localparam logic [16:0] V_ZERO    = 17'b0000000000_00_00_00_0;
  localparam logic [16:0] V_IF_RDY  = 17'b1001010000_01_00_00_0;
  localparam logic [16:0] V_IF_WAIT = 17'b0001000000_01_00_00_0;
  localparam logic [16:0] V_ID      = 17'b0000000000_11_00_00_0;
  localparam logic [16:0] V_MADR    = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] V_MRD     = 17'b0011000000_00_00_00_0;
  localparam logic [16:0] V_MWB     = 17'b0000001010_00_00_00_0;
  localparam logic [16:0] V_MWR     = 17'b0010100000_00_00_00_0;
  localparam logic [16:0] V_REXE    = 17'b0000000001_00_10_00_0;
  localparam logic [16:0] V_RWB     = 17'b0000000110_00_00_00_0;
  localparam logic [16:0] V_BEQ     = 17'b0100000001_00_01_01_0;
  localparam logic [16:0] V_JMP     = 17'b1000000000_00_00_10_0;
  localparam logic [16:0] V_IEXE    = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] V_IWB     = 17'b0000000010_00_00_00_0;
  localparam logic [16:0] V_ILL     = 17'b0000000000_00_00_00_1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       Op = 6'd0;
  logic             MemReady = 1'b1;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic             MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0]       ALUSrcB, ALUOp, PCSource;
  logic [3:0]       State;
  logic [CNT_W-1:0] InstrCnt;
  logic [16:0]      outs;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};

  mc_main_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .IllegalOp(IllegalOp), .State(State), .InstrCnt(InstrCnt)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    MemReady = 1'b1;
    Op = 6'd0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (outs !== V_ZERO || State !== 4'd0 || InstrCnt !== 4'd0)
        $display("FAIL reset cycle %0d: outs=%b state=%0d cnt=%0d, expected outs=%b state=0 cnt=0",
                 i, outs, State, InstrCnt, V_ZERO);
      else passed++;
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (State !== 4'd0 || outs !== V_IF_RDY || InstrCnt !== 4'd0)
      $display("FAIL reset release: state=%0d outs=%b cnt=%0d, expected state=0 outs=%b cnt=0",
               State, outs, InstrCnt, V_IF_RDY);
    else passed++;
  endtask

  task automatic test_lw();
    logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [16:0] eo [6] = '{V_IF_RDY, V_ID, V_MADR, V_MRD, V_MWB, V_IF_RDY};
    logic [3:0]  ec [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      Op = 6'b100011;
      MemReady = 1'b1;
      #1;
      total++;
      if (State !== es[i] || outs !== eo[i] || InstrCnt !== ec[i])
        $display("FAIL lw step %0d: state=%0d outs=%b cnt=%0d, expected state=%0d outs=%b cnt=%0d",
                 i, State, outs, InstrCnt, es[i], eo[i], ec[i]);
      else passed++;
    end
  endtask

  task automatic test_sw_wait();
    logic        er [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0]  es [10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    logic [16:0] eo [10] = '{V_IF_WAIT, V_IF_WAIT, V_IF_RDY, V_ID, V_MADR,
                             V_MWR, V_MWR, V_MWR, V_MWR, V_IF_RDY};
    logic [3:0]  ec [10] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
      Op = 6'b101011;
      MemReady = er[i];
      #1;
      total++;
      if (State !== es[i] || outs !== eo[i] || InstrCnt !== ec[i])
        $display("FAIL sw_wait step %0d: state=%0d outs=%b cnt=%0d, expected state=%0d outs=%b cnt=%0d",
                 i, State, outs, InstrCnt, es[i], eo[i], ec[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  eop [8] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000,
                             6'b000100, 6'b000100, 6'b000100, 6'b000100};
    logic [3:0]  es  [8] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd8, 4'd0};
    logic [16:0] eo  [8] = '{V_IF_RDY, V_ID, V_REXE, V_RWB, V_IF_RDY, V_ID, V_BEQ, V_IF_RDY};
    logic [3:0]  ec  [8] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      Op = eop[i];
      MemReady = 1'b1;
      #1;
      total++;
      if (State !== es[i] || outs !== eo[i] || InstrCnt !== ec[i])
        $display("FAIL rtype_beq step %0d: state=%0d outs=%b cnt=%0d, expected state=%0d outs=%b cnt=%0d",
                 i, State, outs, InstrCnt, es[i], eo[i], ec[i]);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    Op = 6'b111111;
    MemReady = 1'b1;
    cyc();
    total++;
    if (State !== 4'd1 || outs !== V_ID)
      $display("FAIL illegal decode: state=%0d outs=%b, expected state=1 outs=%b", State, outs, V_ID);
    else passed++;
    for (int i = 0; i < 12; i++) begin
      cyc();
      MemReady = i[0];
      #1;
      total++;
      if (State !== 4'd15 || outs !== V_ILL || InstrCnt !== 4'd4)
        $display("FAIL illegal hold %0d: state=%0d outs=%b cnt=%0d, expected state=15 outs=%b cnt=4",
                 i, State, outs, InstrCnt, V_ILL);
      else passed++;
    end
    MemReady = 1'b1;
    rst_n = 1'b0;
    #1;
    total++;
    if (State !== 4'd0 || outs !== V_ZERO || InstrCnt !== 4'd0)
      $display("FAIL illegal reset: state=%0d outs=%b cnt=%0d, expected state=0 outs=%b cnt=0",
               State, outs, InstrCnt, V_ZERO);
    else passed++;
    cyc();
    rst_n = 1'b1;
    #1;
    total++;
    if (State !== 4'd0 || outs !== V_IF_RDY || IllegalOp !== 1'b0)
      $display("FAIL illegal release: state=%0d outs=%b, expected state=0 outs=%b", State, outs, V_IF_RDY);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [3:0] exp_cnt;
    Op = 6'b000010;
    MemReady = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp_cnt = 4'(k);
      total++;
      if (State !== 4'd0 || InstrCnt !== exp_cnt)
        $display("FAIL wrap fetch %0d: state=%0d cnt=%0d, expected state=0 cnt=%0d", k, State, InstrCnt, exp_cnt);
      else passed++;
      cyc();
      cyc();
      #1;
      total++;
      if (State !== 4'd9 || outs !== V_JMP)
        $display("FAIL wrap jmp %0d: state=%0d outs=%b, expected state=9 outs=%b", k, State, outs, V_JMP);
      else passed++;
      cyc();
    end
    total++;
    if (State !== 4'd0 || InstrCnt !== 4'd0)
      $display("FAIL wrap to zero: state=%0d cnt=%0d, expected state=0 cnt=0", State, InstrCnt);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
    logic [16:0] eo [5] = '{V_IF_RDY, V_ID, V_IEXE, V_IWB, V_IF_RDY};
    logic [3:0]  ec [5] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      Op = 6'b001000;
      MemReady = 1'b1;
      #1;
      total++;
      if (State !== es[i] || outs !== eo[i] || InstrCnt !== ec[i])
        $display("FAIL addi step %0d: state=%0d outs=%b cnt=%0d, expected state=%0d outs=%b cnt=%0d",
                 i, State, outs, InstrCnt, es[i], eo[i], ec[i]);
      else passed++;
    end
    cyc();
    cyc();
    total++;
    if (State !== 4'd10)
      $display("FAIL reset_mid reach iexe: state=%0d, expected 10", State);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (State !== 4'd0 || InstrCnt !== 4'd0 || outs !== V_ZERO)
      $display("FAIL reset_mid async: state=%0d cnt=%0d outs=%b, expected state=0 cnt=0 outs=%b",
               State, InstrCnt, outs, V_ZERO);
    else passed++;
    cyc();
    rst_n = 1'b1;
    #1;
    total++;
    if (State !== 4'd0 || InstrCnt !== 4'd0 || outs !== V_IF_RDY)
      $display("FAIL reset_mid release: state=%0d cnt=%0d outs=%b, expected state=0 cnt=0 outs=%b",
               State, InstrCnt, outs, V_IF_RDY);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_back_to_back();
    test_illegal();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Main control FSM of the multi-cycle MIPS processor; sits directly upstream of the ALU control decoder and drives its ALUOp input.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath enable and mux select.
- Handles a variable-latency memory through a ready handshake.
- Counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter InstrCnt

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
Op  in  6  opcode field from instruction register
MemReady  in  1  memory completes current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU Zero (beq)
IorD  out  1  0=PC addresses memory, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemtoReg  out  1  writeback source 0=ALUOut, 1=MDR
RegDst  out  1  dest reg 0=rt, 1=rd
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=register A
ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
ALUOp  out  2  00=add, 01=sub, 10=R-type (funct decoded downstream)
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
IllegalOp  out  1  halted on unsupported opcode
State  out  4  current state (debug)
InstrCnt  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
Moore FSM:
- One 4-bit state register.
- Outputs are decoded only from state, except the two MemReady qualifiers in IF.
- Any output not listed as asserted in a state is 0.

States, with encoding, asserted outputs and next state:
- IF=0: MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=MemReady. Next: ID if MemReady, else IF.
- ID=1: ALUSrcB=11, ALUOp=00. Next by Op:
  - 100011 or 101011 -> MADR
  - 000000 -> REXE
  - 000100 -> BEQ
  - 000010 -> JMP
  - 001000 -> IEXE
  - any other value -> ILL
- MADR=2: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MRD if Op=100011, else MWR.
- MRD=3: MemRead=1, IorD=1. Next: MWB if MemReady, else MRD.
- MWB=4: RegWrite=1, MemtoReg=1, RegDst=0. Next: IF; retire.
- MWR=5: MemWrite=1, IorD=1, held until MemReady. Next: IF on MemReady; retire on that edge.
- REXE=6: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: RWB.
- RWB=7: RegWrite=1, RegDst=1, MemtoReg=0. Next: IF; retire.
- BEQ=8: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next: IF; retire.
- JMP=9: PCWrite=1, PCSource=10. Next: IF; retire.
- IEXE=10: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: IWB.
- IWB=11: RegWrite=1, RegDst=0, MemtoReg=0. Next: IF; retire.
- ILL=15: IllegalOp=1, all enables 0; absorbing, only reset exits.
- Encodings 12-14: next state IF, all outputs 0.

Reset:
- rst_n low immediately forces state=IF and InstrCnt=0.
- While rst_n is low, all outputs are forced to 0 combinationally, so no spurious IRWrite/PCWrite/MemRead during reset.
- Reset mid-instruction aborts it; that instruction is not counted.
- The first fetch begins on the first clk edge after rst_n goes high.

Counter:
- InstrCnt increments by 1 on each clock edge that moves the FSM into IF from a retire state.
- Wraps to 0 after all-ones.

Latency with MemReady tied high:
- beq and j: 3 cycles.
- R-type, addi, sw: 4 cycles.
- lw: 5 cycles.
- Each memory state extends by the number of cycles MemReady stays low.

Decomposition:
- Shared package holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - state encoding constants S_IF..S_ILL;
  - ALUOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_RTYPE=10, which are also used by the ALU control block;
  - ALUSrcB and PCSource select constants.
- No sub-module: next-state logic, output decode and counter fit in one module.

Test Plan:
- Reset held low for 3 cycles with MemReady=1 -> all outputs 0 and InstrCnt=0; after release, State=0, MemRead=1, IRWrite=1, PCWrite=1 in the first cycle.
- lw (Op=100011), MemReady=1 -> State sequence 0,1,2,3,4,0; ALUOp=00 in IF/ID/MADR; RegWrite=1 and MemtoReg=1 only in state 4; InstrCnt goes 0->1.
- sw with MemReady low 3 cycles in MWR -> MemWrite held 4 cycles; IorD=1 throughout; RegWrite never asserted; InstrCnt increments only once.
- R-type then beq, MemReady=1 -> REXE shows ALUOp=10 and RWB shows RegDst=1; BEQ shows ALUOp=01, PCWriteCond=1, PCSource=01; InstrCnt=2 after 7 cycles.
- Op=111111 -> ID to ILL; IllegalOp=1 with all enables 0 for 10+ cycles; a pulse on rst_n returns State to 0 and clears IllegalOp.
- Counter preloaded near CNT_W all-ones via 4-bit parameter override, then j instructions -> InstrCnt wraps 15->0; asserting rst_n low mid-IEXE gives InstrCnt=0 and State=0 asynchronously.
